// File: rtl/frame_bank_scheduler_pkg.sv
//==============================================================================
// Package     : frame_buf_pkg
// Description : Shared types, constants and helpers for the ping-pong frame
//               buffer scheduler (state encoding, pixel type, frame size,
//               saturating drop counter increment).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package frame_buf_pkg;

    // Scheduler states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        READY    = 2'd2
    } fbs_state_t;

    // RGB565 pixel.
    typedef logic [15:0] pixel_t;

    // Default image geometry and the resulting frame size.
    localparam int DEF_IMG_WIDTH  = 176;
    localparam int DEF_IMG_HEIGHT = 240;
    localparam int FRAME_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    // Dropped-frame counter saturates here.
    localparam int DROP_CNT_MAX   = 255;

    // Frame size for an arbitrary geometry (used by parameterised modules).
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    // Saturating +1 for the 8-bit drop counter.
    function automatic logic [7:0] drop_inc(input logic [7:0] cnt);
        return (cnt == 8'(DROP_CNT_MAX)) ? cnt : cnt + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_bank_scheduler_if.sv
//==============================================================================
// Interface   : frame_bank_scheduler_if
// Description : Bundles the camera input stream, the VGA vsync marker and the
//               frame-buffer write / bank-select outputs of the scheduler.
//               master : camera/display side (drives cam_*, vga_vsync_start)
//               slave  : scheduler (drives wr_*, rd_bank, frame_done, drop_cnt)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface frame_bank_scheduler_if #(
    parameter int ADDR_WIDTH = 16
);
    import frame_buf_pkg::*;

    logic                  cam_vsync;
    logic                  cam_we;
    pixel_t                cam_wdata;
    logic                  vga_vsync_start;

    logic                  wr_en;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    pixel_t                wr_data;
    logic                  rd_bank;
    logic                  frame_done;
    logic [7:0]            drop_cnt;

    modport master (
        output cam_vsync, cam_we, cam_wdata, vga_vsync_start,
        input  wr_en, wr_bank, wr_addr, wr_data, rd_bank, frame_done, drop_cnt
    );

    modport slave (
        input  cam_vsync, cam_we, cam_wdata, vga_vsync_start,
        output wr_en, wr_bank, wr_addr, wr_data, rd_bank, frame_done, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/frame_bank_scheduler_wr_addr_counter.sv
//==============================================================================
// Module      : frame_wr_addr_counter
// Description : Pixel address counter for one frame. Clears to 0, increments
//               on i_incr and wraps to 0 after the last pixel. o_last flags the
//               terminal count (FRAME_PIXELS-1).
// Ports       : clk, rst_n (async active-low), i_clear, i_incr,
//               o_count (current address), o_last (terminal count)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_wr_addr_counter #(
    parameter int FRAME_PIXELS = 8,
    parameter int ADDR_WIDTH   = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_clear,
    input  wire logic                  i_incr,
    output logic      [ADDR_WIDTH-1:0] o_count,
    output logic                       o_last
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

    logic [ADDR_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr) begin
            // Wrap at the end of the frame so the address never leaves range.
            r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
//==============================================================================
// Module      : frame_bank_scheduler
// Description : Ping-pong scheduler for a two-bank RGB565 frame buffer.
//               Converts the camera pixel stream into buffer writes on the
//               write bank and hands the display a read bank that only swaps
//               at VGA vertical blank, once a complete frame is ready.
//               Counts camera frames that had to be dropped (saturating).
// Ports       : clk, rst_n (async active-low)
//               bus    : frame_bank_scheduler_if.slave (camera in, writes out)
//               freeze : hold the displayed bank (FRAME_FREEZE_EN builds only)
// Config      : FRAME_FREEZE_EN - adds the freeze input; undefined = no freeze
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_bank_scheduler
    import frame_buf_pkg::*;
#(
    parameter int IMG_WIDTH  = 176,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
`ifdef FRAME_FREEZE_EN
    input  wire logic              freeze,
`endif
    frame_bank_scheduler_if.slave  bus
);

    localparam int c_FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT);

    fbs_state_t            r_state;
    logic                  r_wr_en;
    logic                  r_wr_bank;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    pixel_t                r_wr_data;
    logic                  r_frame_done;
    logic [7:0]            r_drop_cnt;

    logic                  w_freeze;
    logic                  w_swap;
    logic                  w_cnt_clear;
    logic                  w_cnt_incr;
    logic                  w_cnt_last;
    logic [ADDR_WIDTH-1:0] w_cnt;

`ifdef FRAME_FREEZE_EN
    assign w_freeze = freeze;
`else
    assign w_freeze = 1'b0;
`endif

    // A swap happens only from READY, and never while the display is frozen.
    assign w_swap = (r_state == READY) && bus.vga_vsync_start && !w_freeze;

    // Every start-of-frame restarts the address count; in READY the counter
    // already sits at 0, so clearing there is harmless. Pixels only count in
    // FILL, and a coincident vsync discards the pixel.
    assign w_cnt_clear = bus.cam_vsync;
    assign w_cnt_incr  = (r_state == FILL) && bus.cam_we && !bus.cam_vsync;

    frame_wr_addr_counter #(
        .FRAME_PIXELS (c_FRAME_PIXELS),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_cnt_clear),
        .i_incr  (w_cnt_incr),
        .o_count (w_cnt),
        .o_last  (w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_SOF;
            r_wr_en      <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            unique case (r_state)
                WAIT_SOF: begin
                    if (bus.cam_vsync) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (bus.cam_vsync) begin
                        // Short frame: restart the same bank from address 0.
                        r_drop_cnt <= drop_inc(r_drop_cnt);
                    end else if (bus.cam_we) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_cnt;
                        r_wr_data <= bus.cam_wdata;
                        if (w_cnt_last) begin
                            r_state <= READY;
                        end
                    end
                end
                READY: begin
                    if (w_swap) begin
                        r_wr_bank    <= ~r_wr_bank;
                        r_frame_done <= 1'b1;
                        // A camera frame starting at the swap goes straight
                        // into the freshly released bank.
                        r_state      <= bus.cam_vsync ? FILL : WAIT_SOF;
                    end else if (bus.cam_vsync) begin
                        if (w_freeze) begin
                            r_state <= FILL;
                        end else begin
                            r_drop_cnt <= drop_inc(r_drop_cnt);
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_SOF;
                end
            endcase
        end
    end

    // The read bank is always the other bank, so the two can never collide.
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_bank    = r_wr_bank;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.rd_bank    = ~r_wr_bank;
    assign bus.frame_done = r_frame_done;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
//==============================================================================
// Module      : tb_frame_bank_scheduler
// Description : Directed self-checking bench for frame_bank_scheduler with a
//               4x2 image (8 pixels per frame). Freeze steps are included when
//               FRAME_FREEZE_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_frame_bank_scheduler;
    import frame_buf_pkg::*;

    localparam int c_W  = 4;
    localparam int c_H  = 2;
    localparam int c_AW = 3;

    logic clk;
    logic rst_n;
`ifdef FRAME_FREEZE_EN
    logic freeze;
`endif

    int checks = 0;
    int errors = 0;

    frame_bank_scheduler_if #(.ADDR_WIDTH(c_AW)) bus ();

    frame_bank_scheduler #(
        .IMG_WIDTH  (c_W),
        .IMG_HEIGHT (c_H),
        .ADDR_WIDTH (c_AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef FRAME_FREEZE_EN
        .freeze (freeze),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge and inputs
    // are changed at the same point, well away from the next edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.cam_vsync       = 1'b0;
        bus.cam_we          = 1'b0;
        bus.cam_wdata       = '0;
        bus.vga_vsync_start = 1'b0;
`ifdef FRAME_FREEZE_EN
        freeze              = 1'b0;
`endif

        // ---------------- 1. reset ----------------
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_wr_bank", bus.wr_bank, 0);
        chk("rst_rd_bank", bus.rd_bank, 1);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        chk("rst_frame_done", bus.frame_done, 0);

        // vsync from the display outside READY does nothing
        bus.vga_vsync_start = 1'b1;
        cycle();
        bus.vga_vsync_start = 1'b0;
        chk("idle_vga_rd_bank", bus.rd_bank, 1);
        chk("idle_vga_frame_done", bus.frame_done, 0);

        // start a frame, write two pixels, then reset mid-frame
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        bus.cam_we    = 1'b1;
        bus.cam_wdata = 16'hAAAA;
        cycle();
        chk("pre_rst_wr_en", bus.wr_en, 1);
        chk("pre_rst_addr0", bus.wr_addr, 0);
        cycle();
        chk("pre_rst_addr1", bus.wr_addr, 1);
        bus.cam_we = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("midrst_wr_en", bus.wr_en, 0);
        chk("midrst_wr_addr", bus.wr_addr, 0);
        chk("midrst_wr_data", bus.wr_data, 0);
        cycle();
        rst_n         = 1'b1;
        bus.cam_we    = 1'b1;
        bus.cam_wdata = 16'h5555;
        cycle();
        chk("post_rst_no_write0", bus.wr_en, 0);
        cycle();
        chk("post_rst_no_write1", bus.wr_en, 0);
        bus.cam_we = 1'b0;

        // ---------------- 2. full frame ----------------
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.cam_we    = 1'b1;
            bus.cam_wdata = 16'(i + 1);
            cycle();
            chk("full_wr_en", bus.wr_en, 1);
            chk("full_wr_addr", bus.wr_addr, i);
            chk("full_wr_data", bus.wr_data, i + 1);
            chk("full_wr_bank", bus.wr_bank, 0);
        end
        bus.cam_wdata = 16'h0009;
        cycle();
        chk("full_9th_ignored", bus.wr_en, 0);
        bus.cam_we = 1'b0;
        bus.vga_vsync_start = 1'b1;
        cycle();
        bus.vga_vsync_start = 1'b0;
        chk("swap1_rd_bank", bus.rd_bank, 0);
        chk("swap1_wr_bank", bus.wr_bank, 1);
        chk("swap1_frame_done", bus.frame_done, 1);
        cycle();
        chk("swap1_frame_done_1cyc", bus.frame_done, 0);
        chk("swap1_rd_hold", bus.rd_bank, 0);

        // ---------------- 3. short frame (bank 1) ----------------
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cam_we    = 1'b1;
            bus.cam_wdata = 16'h0100 + 16'(i);
            cycle();
            chk("short_wr_addr", bus.wr_addr, i);
        end
        bus.cam_we    = 1'b0;
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        chk("short_drop", bus.drop_cnt, 1);
        chk("short_no_write", bus.wr_en, 0);
        for (int i = 0; i < 8; i++) begin
            bus.cam_we    = 1'b1;
            bus.cam_wdata = 16'h00F0 + 16'(i);
            cycle();
            chk("refill_wr_addr", bus.wr_addr, i);
            chk("refill_wr_data", bus.wr_data, 16'h00F0 + i);
            chk("refill_wr_bank", bus.wr_bank, 1);
        end
        bus.cam_we = 1'b0;

        // ---------------- 4. drops while READY ----------------
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        cycle();
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        chk("ready_drop", bus.drop_cnt, 3);
        chk("ready_no_write", bus.wr_en, 0);
        chk("ready_rd_bank", bus.rd_bank, 0);
        bus.cam_we = 1'b1;
        cycle();
        bus.cam_we = 1'b0;
        chk("ready_we_ignored", bus.wr_en, 0);

        // ---------------- 5. simultaneous swap + new frame ----------------
        bus.vga_vsync_start = 1'b1;
        bus.cam_vsync       = 1'b1;
        cycle();
        bus.vga_vsync_start = 1'b0;
        bus.cam_vsync       = 1'b0;
        chk("sim_rd_bank", bus.rd_bank, 1);
        chk("sim_wr_bank", bus.wr_bank, 0);
        chk("sim_frame_done", bus.frame_done, 1);
        chk("sim_drop_unchanged", bus.drop_cnt, 3);
        for (int i = 0; i < 8; i++) begin
            bus.cam_we    = 1'b1;
            bus.cam_wdata = 16'h1234 + 16'(i);
            cycle();
            chk("sim_wr_addr", bus.wr_addr, i);
            chk("sim_wr_bank_w", bus.wr_bank, 0);
        end
        bus.cam_we = 1'b0;

        // ---------------- drop counter saturation ----------------
        repeat (251) begin
            bus.cam_vsync = 1'b1;
            cycle();
            bus.cam_vsync = 1'b0;
            cycle();
        end
        chk("drop_254", bus.drop_cnt, 254);
        repeat (49) begin
            bus.cam_vsync = 1'b1;
            cycle();
            bus.cam_vsync = 1'b0;
            cycle();
        end
        chk("drop_sat_255", bus.drop_cnt, 255);
        chk("drop_rd_bank", bus.rd_bank, 1);

`ifdef FRAME_FREEZE_EN
        // ---------------- 6. freeze ----------------
        freeze = 1'b1;
        cycle();
        bus.vga_vsync_start = 1'b1;
        cycle();
        bus.vga_vsync_start = 1'b0;
        chk("frz_rd_bank", bus.rd_bank, 1);
        chk("frz_frame_done", bus.frame_done, 0);
        bus.cam_vsync = 1'b1;
        cycle();
        bus.cam_vsync = 1'b0;
        chk("frz_drop", bus.drop_cnt, 255);
        for (int i = 0; i < 8; i++) begin
            bus.cam_we    = 1'b1;
            bus.cam_wdata = 16'hBEE0 + 16'(i);
            cycle();
            chk("frz_wr_en", bus.wr_en, 1);
            chk("frz_wr_addr", bus.wr_addr, i);
            chk("frz_wr_bank", bus.wr_bank, 0);
        end
        bus.cam_we = 1'b0;
        freeze     = 1'b0;
        cycle();
`endif

        // ---------------- final swap ----------------
        bus.vga_vsync_start = 1'b1;
        cycle();
        bus.vga_vsync_start = 1'b0;
        chk("swap_end_rd_bank", bus.rd_bank, 0);
        chk("swap_end_wr_bank", bus.wr_bank, 1);
        chk("swap_end_frame_done", bus.frame_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
